act_sched: RTL and testbench

Round-robin scheduler that shares one combinational activation unit between `N_REQ` accumulator lanes of the CNN datapath. It accepts 2·`WIDTH`-bit accumulator values over per-lane valid/ready handshakes and registers the chosen operand onto the shared unit's input. It then captures the `WIDTH`-bit activation result and returns it tagged with the originating lane ID over a single valid/ready result port. One operation is in flight at a time, and the unit's inputs are stable for a full cycle.

---
 rtl/act_sched.sv | 88 ++++++++
 tb/tb_act_sched.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/act_sched.sv
// Round-robin scheduler time-sharing one combinational activation unit among
// N_REQ accumulator lanes; one operation in flight, result tagged with lane ID.
module act_sched #(
  parameter int WIDTH = 16,
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*2*WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic [2*WIDTH-1:0]         act_x,
  input  logic [WIDTH-1:0]           act_out,
  output logic                       res_valid,
  output logic [ID_W-1:0]            res_id,
  output logic [WIDTH-1:0]           res_data,
  input  logic                       res_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [ID_W:0]   NR   = (ID_W+1)'(N_REQ);
  localparam logic [ID_W-1:0] LAST = ID_W'(N_REQ-1);

  logic [1:0]                        state;
  logic [ID_W-1:0]                   rr_ptr, id_r, gnt_idx;
  logic [N_REQ-1:0][ID_W-1:0]        lane_at;
  logic [N_REQ-1:0][2*WIDTH-1:0]     lane_d;
  logic                              any_vld, can_gnt, gnt;

  assign lane_d = req_data;

  // lane_at[k] is the lane k positions after rr_ptr, wrapping at N_REQ
  for (genvar k = 0; k < N_REQ; k++) begin : g_rot
    logic [ID_W:0] sum;
    assign sum        = {1'b0, rr_ptr} + (ID_W+1)'(k);
    assign lane_at[k] = (sum >= NR) ? ID_W'(sum - NR) : sum[ID_W-1:0];
  end

  // Scan from the far end so the lowest rotated offset wins.
  always_comb begin
    gnt_idx = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      if (req_valid[lane_at[k]]) gnt_idx = lane_at[k];
    end
  end

  assign any_vld   = |req_valid;
  assign can_gnt   = rst_n && ((state == IDLE) || (state == DONE && res_ready));
  assign gnt       = can_gnt && any_vld;
  assign req_ready = gnt ? (N_REQ'(1) << gnt_idx) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      act_x     <= '0;
      id_r      <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_data  <= '0;
    end else begin
      if (gnt) begin
        act_x  <= lane_d[gnt_idx];
        id_r   <= gnt_idx;
        rr_ptr <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
      end
      case (state)
        IDLE: if (gnt) state <= BUSY;
        BUSY: begin
          res_data  <= act_out;
          res_id    <= id_r;
          res_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (res_ready) begin
          res_valid <= 1'b0;
          state     <= gnt ? BUSY : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_act_sched.sv
// Directed bench for act_sched (WIDTH=8, N_REQ=4) with a behavioural
// activation model (|X+1|+|X-1|)>>>1 driving act_out.
module tb_act_sched;

  localparam int WIDTH = 8;
  localparam int N_REQ = 4;
  localparam int ID_W  = 2;
  localparam int OW    = 2*WIDTH;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ*OW-1:0]       req_data;
  logic [N_REQ-1:0]          req_ready;
  logic [OW-1:0]             act_x;
  logic [WIDTH-1:0]          act_out;
  logic                      res_valid;
  logic [ID_W-1:0]           res_id;
  logic [WIDTH-1:0]          res_data;
  logic                      res_ready;

  int n_chk  = 0;
  int n_pass = 0;

  act_sched #(.WIDTH(WIDTH), .N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .act_x(act_x), .act_out(act_out),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
    .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] act_model(input logic [OW-1:0] x);
    int a, b;
    a = int'($signed(x)) + 1;
    b = int'($signed(x)) - 1;
    if (a < 0) a = -a;
    if (b < 0) b = -b;
    return WIDTH'((a + b) >>> 1);
  endfunction

  assign act_out = act_model(act_x);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    res_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic set_lane(input int l, input logic [OW-1:0] v);
    req_data[l*OW +: OW] = v;
  endtask

  // lane 2 alone, starting from IDLE, consumer always ready
  task automatic single(input logic [OW-1:0] x, input logic [WIDTH-1:0] e);
    set_lane(2, x);
    req_valid = 4'b0100;
    #1 chk("single_rdy", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    chk("single_actx", 32'(act_x), 32'(x));
    chk("single_busy_rv", 32'(res_valid), 32'd0);
    step();
    chk("single_rv", 32'(res_valid), 32'd1);
    chk("single_id", 32'(res_id), 32'd2);
    chk("single_data", 32'(res_data), 32'(e));
    step();
    chk("single_retire", 32'(res_valid), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    res_ready = 1'b1;

    // reset values with all lanes requesting
    for (int l = 0; l < N_REQ; l++) set_lane(l, OW'(16'h0100 + l));
    req_valid = 4'hF;
    step(); step(); step();
    chk("rst_rdy", 32'(req_ready), 32'd0);
    chk("rst_rv", 32'(res_valid), 32'd0);
    chk("rst_actx", 32'(act_x), 32'd0);
    chk("rst_data", 32'(res_data), 32'd0);
    chk("rst_id", 32'(res_id), 32'd0);
    rst_n = 1'b1;
    #1 chk("rst_first_gnt", 32'(req_ready), 32'h1);
    step();
    chk("rst_first_actx", 32'(act_x), 32'h0100);
    req_valid = '0;
    step(); step();

    // single lane, three operands
    do_reset();
    single(16'd5, 8'd5);
    single(16'd0, 8'd1);
    single(16'hFFFD, 8'd3);

    // round-robin fairness, all lanes continuously valid
    do_reset();
    for (int l = 0; l < N_REQ; l++) set_lane(l, OW'(l*10 + 1));
    req_valid = 4'hF;
    for (int g = 0; g < 6; g++) begin
      #1 chk("rr_rdy", 32'(req_ready), 32'(1 << (g % 4)));
      step();
      chk("rr_actx", 32'(act_x), 32'((g % 4)*10 + 1));
      step();
      chk("rr_rv", 32'(res_valid), 32'd1);
      chk("rr_id", 32'(res_id), 32'(g % 4));
    end
    req_valid = '0;
    step();

    // wrap after lane 3 and skip invalid lane 0
    do_reset();
    req_valid = 4'b1000;
    #1 chk("wrap_rdy3", 32'(req_ready), 32'h8);
    step();
    req_valid = 4'b0110;
    step();
    chk("wrap_id3", 32'(res_id), 32'd3);
    chk("wrap_rdy1", 32'(req_ready), 32'h2);
    step();
    req_valid = 4'b0100;
    step();
    chk("wrap_id1", 32'(res_id), 32'd1);
    chk("wrap_rdy2", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    step();
    chk("wrap_id2", 32'(res_id), 32'd2);
    step();

    // backpressure in DONE with lane 0 waiting
    do_reset();
    set_lane(1, 16'd7);
    set_lane(0, 16'hFFF6);
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    step();
    res_ready = 1'b0;
    req_valid = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      #1 chk("bp_rdy", 32'(req_ready), 32'd0);
      chk("bp_rv", 32'(res_valid), 32'd1);
      chk("bp_id", 32'(res_id), 32'd1);
      chk("bp_data", 32'(res_data), 32'd7);
      chk("bp_actx", 32'(act_x), 32'd7);
      step();
    end
    res_ready = 1'b1;
    #1 chk("bp_release_rdy", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    chk("bp_actx0", 32'(act_x), 32'hFFF6);
    chk("bp_rv_drop", 32'(res_valid), 32'd0);
    step();
    chk("bp_id0", 32'(res_id), 32'd0);
    chk("bp_data0", 32'(res_data), 32'd10);
    step();

    // reset during BUSY discards the operation and the pointer
    do_reset();
    set_lane(2, 16'd9);
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1 chk("mid_rv", 32'(res_valid), 32'd0);
      chk("mid_rdy", 32'(req_ready), 32'd0);
      step();
    end
    chk("mid_actx", 32'(act_x), 32'd0);
    req_valid = 4'hF;
    #1 chk("mid_ptr0", 32'(req_ready), 32'h1);
    req_valid = '0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
